// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Outputs decode the current state; fetch and memory-access states wait on mem_ready.
module mips_multicycle_control #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSrc,
  output logic           AluOp1,
  output logic           AluOp0,
  output logic [3:0]     state,
  output logic           illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ORIEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;

  state_t r_state;
  logic   r_illegal_op;

  // Branch resolution happens in the datapath (PCWriteCond AND zero), so the FSM ignores zero.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
    end else begin
      r_illegal_op <= 1'b0;
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_ORI:       r_state <= S_ORIEX;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_state      <= S_FETCH;
              r_illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LW)      r_state <= S_MEMRD;
          else if (opcode == OP_SW) r_state <= S_MEMWR;
          else                      r_state <= S_FETCH;
        end
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_IMMWB;
        S_ORIEX:  r_state <= S_IMMWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    AluOp1      = 1'b0;
    AluOp0      = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        AluOp1  = 1'b1;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp0      = 1'b1;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
      end
      S_ORIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        AluOp1  = 1'b1;
        AluOp0  = 1'b1;
      end
      S_IMMWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign state      = r_state;
  assign illegal_op = r_illegal_op;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-path reference model plus directed scenarios and random traffic.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       AluOp1, AluOp0, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .AluOp1(AluOp1), .AluOp0(AluOp0), .state(state), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcsrc;
    logic a1, a0;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                    RegWrite, ALUSrcA, ALUSrcB, PCSrc, AluOp1, AluOp0};

  // Control word each state must present, straight from the state table.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic mr);
    ctl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
      4'd1:  c.asb = 2'b11;
      4'd2, 4'd9: begin c.asa = 1; c.asb = 2'b10; end
      4'd3:  begin c.mrd = 1; c.iord = 1; end
      4'd4:  begin c.rw = 1; c.m2r = 1; end
      4'd5:  begin c.mwr = 1; c.iord = 1; end
      4'd6:  begin c.asa = 1; c.a1 = 1; end
      4'd7:  begin c.rw = 1; c.rdst = 1; end
      4'd8:  begin c.asa = 1; c.a0 = 1; c.pcwc = 1; c.pcsrc = 2'b01; end
      4'd10: begin c.asa = 1; c.asb = 2'b10; c.a1 = 1; c.a0 = 1; end
      4'd11: c.rw = 1;
      4'd12: begin c.pcw = 1; c.pcsrc = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  // States an instruction visits after DECODE; empty for unsupported opcodes.
  typedef logic [3:0] path_t[$];
  function automatic path_t route(input logic [5:0] op);
    path_t p;
    p = {};
    case (op)
      LW:   p = {4'd2, 4'd3, 4'd4};
      SW:   p = {4'd2, 4'd5};
      RT:   p = {4'd6, 4'd7};
      BEQ:  p = {4'd8};
      ADDI: p = {4'd9, 4'd11};
      ORI:  p = {4'd10, 4'd11};
      JMP:  p = {4'd12};
      default: p = {};
    endcase
    return p;
  endfunction

  logic [3:0] m_state = 4'd0;
  logic       m_ill = 1'b0;
  bit         m_valid = 1'b0;
  path_t      m_path;

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 4'd0;
      m_ill   <= 1'b0;
      m_valid <= 1'b1;
      m_path = {};
    end else if (m_valid) begin
      m_ill <= (m_state == 4'd1) && (route(opcode).size() == 0);
      if (!((m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5) && !mem_ready)) begin
        if (m_state == 4'd0) begin
          m_state <= 4'd1;
        end else begin
          if (m_state == 4'd1) m_path = route(opcode);
          if (m_path.size() > 0) m_state <= m_path.pop_front();
          else m_state <= 4'd0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (state !== m_state || dut_ctl !== exp_ctl(m_state, mem_ready) || illegal_op !== m_ill) begin
        failures++;
        $display("FAIL model t=%0t state=%0d want=%0d ctl=%h want=%h illegal_op=%b want=%b",
                 $time, state, m_state, dut_ctl, exp_ctl(m_state, mem_ready), illegal_op, m_ill);
      end
      checks++;
      if ((MemRead && MemWrite) || (RegWrite && !(state == 4'd4 || state == 4'd7 || state == 4'd11))) begin
        failures++;
        $display("FAIL invariant t=%0t state=%0d MemRead=%b MemWrite=%b RegWrite=%b want no overlap",
                 $time, state, MemRead, MemWrite, RegWrite);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic mr);
    @(posedge clk); #1;
    reset = 1'b0; opcode = op; mem_ready = mr; zero = 1'($urandom);
    @(negedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int lwseq[6];
    int mw_cnt;
    logic [5:0] ops[9];
    logic [5:0] cur_op;
    lwseq = '{0, 1, 2, 3, 4, 0};
    ops = '{LW, SW, RT, BEQ, ADDI, ORI, JMP, BAD, 6'h00};
    reset = 1'b1; opcode = 6'($urandom); mem_ready = 1'b0; zero = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      opcode = 6'($urandom); mem_ready = 1'($urandom);
    end

    // Reset released with mem_ready=1, then lw end to end.
    step(LW, 1'b1);
    lit("rst_state", state, 0);   lit("rst_memread", MemRead, 1);
    lit("rst_irwrite", IRWrite, 1); lit("rst_pcwrite", PCWrite, 1);
    lit("rst_alusrcb", ALUSrcB, 1); lit("rst_aluop", {AluOp1, AluOp0}, 0);
    lit("rst_illegal", illegal_op, 0);
    for (int i = 1; i < 6; i++) begin
      step((i == 5) ? RT : LW, 1'b1);
      lit($sformatf("lw_seq%0d", i), state, lwseq[i]);
      if (i == 4) begin
        lit("memwb_regwrite", RegWrite, 1);
        lit("memwb_memtoreg", MemtoReg, 1);
      end
    end

    // R-type, ori, beq ALU-op encodings.
    step(RT, 1'b1);
    step(RT, 1'b1);  lit("exec_state", state, 6); lit("exec_aluop", {AluOp1, AluOp0}, 2);
    step(RT, 1'b1);
    step(ORI, 1'b1);
    step(ORI, 1'b1);
    step(ORI, 1'b1); lit("oriex_state", state, 10); lit("oriex_aluop", {AluOp1, AluOp0}, 3);
    step(ORI, 1'b1);
    step(BEQ, 1'b1);
    step(BEQ, 1'b1);
    step(BEQ, 1'b1); lit("branch_state", state, 8); lit("branch_aluop", {AluOp1, AluOp0}, 1);
    lit("branch_pcwcond", PCWriteCond, 1); lit("branch_pcsrc", PCSrc, 1);

    // Fetch stall for 3 cycles, then sw with a 2-cycle write stall.
    for (int i = 0; i < 3; i++) begin
      step(SW, 1'b0);
      lit("fstall_state", state, 0); lit("fstall_irwrite", IRWrite, 0); lit("fstall_pcwrite", PCWrite, 0);
    end
    step(SW, 1'b1);
    step(SW, 1'b1);
    step(SW, 1'b1);  lit("sw_memadr", state, 2);
    mw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step((i == 3) ? BAD : SW, (i >= 2) ? 1'b1 : 1'b0);
      if (MemWrite) mw_cnt++;
    end
    lit("sw_memwrite_cycles", mw_cnt, 3);
    lit("sw_back_to_fetch", state, 0);

    // Unsupported opcode: one-cycle illegal_op pulse and return to fetch.
    step(BAD, 1'b1); lit("bad_decode", state, 1); lit("bad_ill_before", illegal_op, 0);
    step(LW, 1'b1);  lit("bad_fetch", state, 0); lit("bad_ill_pulse", illegal_op, 1);
    lit("bad_no_write", {RegWrite, MemWrite}, 0);
    step(LW, 1'b1);  lit("bad_ill_clear", illegal_op, 0);

    // Reset while stalled in MEMRD.
    step(LW, 1'b1);
    step(LW, 1'b0);  lit("memrd_stall", state, 3);
    @(posedge clk); #1; reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    step(LW, 1'b0);
    lit("rst_memrd_state", state, 0); lit("rst_memrd_memread", MemRead, 1);
    lit("rst_memrd_iord", IorD, 0);   lit("rst_memrd_regwrite", RegWrite, 0);
    step(LW, 1'b0);  lit("rst_memrd_no_wb", state, 0);

    // Random traffic; the instruction register only changes while in FETCH.
    cur_op = LW;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      zero = 1'($urandom);
      if (m_state == 4'd0) begin
        cur_op = ops[$urandom_range(0, 8)];
        if (cur_op == 6'h00 && $urandom_range(0, 1) == 1) cur_op = 6'($urandom);
      end
      opcode = cur_op;
    end

    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the 32-bit multicycle MIPS datapath.
- Decodes the 6-bit opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables and muxes, plus the two-bit AluOp pair consumed by the downstream ALU control stage.
- Stalls on a memory-ready handshake.

Parameters:
- OPW, 6, opcode width (fixed; not meant to be overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, no other clock domain
- opcode  in  6  instruction[31:26] from IR
- zero  in  1  ALU zero flag (used in BRANCH only)
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by zero (datapath ANDs)
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  1=MDR to register file write data
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=reg A
- ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- AluOp1  out  1  ALU-control op, high bit
- AluOp0  out  1  ALU-control op, low bit
- state  out  4  current state code (debug/verification)
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- State register, 4 bits. Encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ORIEX=10, IMMWB=11, JUMP=12.
  - Codes 13–15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Reset: synchronous. Asserting reset on any edge forces state=FETCH, including mid-instruction or mid-stall. No partial writes are completed. illegal_op is registered and clears to 0.
- All outputs not listed for a state are 0. AluOp defaults to 00.
- Outputs are combinational decode of state; IRWrite, PCWrite (in FETCH) and the MEMRD advance are additionally gated by mem_ready.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Transition: stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, AluOp=00 (branch target precompute).
  - Next state by opcode:
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 001101 (ori) -> ORIEX
    - 000010 (j) -> JUMP
    - any other -> FETCH, with illegal_op=1 for exactly the following cycle.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, AluOp=00.
  - Next: lw -> MEMRD; sw -> MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Stay until mem_ready=1, then MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Stay until mem_ready=1, then FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, AluOp=10 (funct-decoded).
  - Next: ALUWB.
- ALUWB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, AluOp=01 (subtract), PCWriteCond=1, PCSrc=01.
  - Next: FETCH. The zero input is not used by the FSM.
- ADDIEX:
  - Outputs: ALUSrcA=1, ALUSrcB=10, AluOp=00.
  - Next: IMMWB.
- ORIEX:
  - Outputs: ALUSrcA=1, ALUSrcB=10, AluOp=11 (OR).
  - Next: IMMWB.
- IMMWB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - Next: FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSrc=10.
  - Next: FETCH.
- Latency with mem_ready held at 1: lw 5 cycles; sw, R-type, addi, ori 4 cycles; beq, j 3 cycles. Each stall cycle on mem_ready=0 adds one.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite is 1 only in MEMWB, ALUWB and IMMWB.

Test Plan:
- Reset held 2 cycles in arbitrary state, then released with mem_ready=1 -> state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01, AluOp=00, illegal_op=0.
- lw, mem_ready=1 -> state sequence 0,1,2,3,4,0; MEMWB shows RegWrite=1, MemtoReg=1; 5 cycles total.
- R-type then ori -> EXEC shows AluOp1/AluOp0=1/0; ORIEX shows 1/1; BRANCH (beq) shows 0/1 with PCWriteCond=1, PCSrc=01.
- mem_ready=0 for 3 cycles in FETCH, then sw with mem_ready=0 for 2 cycles in MEMWR:
  - state holds 0 for 3 cycles with IRWrite=0, PCWrite=0;
  - MemWrite=1 held for 3 cycles total;
  - then FETCH.
- Opcode 111111 in DECODE -> next state 0, illegal_op=1 for exactly one cycle, no RegWrite/MemWrite asserted.
- Reset asserted while in MEMRD with mem_ready=0 -> next state 0; MemRead/IorD follow FETCH values; no MEMWB write occurs.
